fetch_unit: RTL

- Instruction-fetch stage of the pipelined CPU. Sits directly upstream of the icache, on the datapath side.
- Owns the PC and drives imemREN/imemaddr to the icache. Consumes ihit/iload.
- Writes the IF/ID pipeline latch and absorbs hazard-unit stall/flush and branch/jump redirects.
- A one-entry hold buffer lets a hit that returns under stall be kept, so it is not refetched.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/fetch_hold_reg.sv | 37 +++
 rtl/fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, IF/ID bundle, fetch FSM states.
// Also holds the halt opcode, which decode uses too.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  typedef enum logic [1:0] {
    RUN,
    REDIR_WAIT,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } if_id_t;

  function automatic logic [5:0] opcode_of(word_t w);
    return w[31:26];
  endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry IF/ID holding buffer.
// Keeps a fetched word that returned while IF/ID was stalled.
module fetch_hold_reg
  import cpu_types_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  if_id_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (clear) begin
      ent_d.valid = 1'b0;
    end else if (load) begin
      ent_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign valid = ent_q.valid;
  assign q     = ent_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, icache request, IF/ID latch.
// Handles stall/flush, redirects and halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t      PC_INIT = 32'h0000_0000,
  parameter logic [5:0] HALT_OP = HALT_OPCODE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        redir_q, redir_d;
  if_id_t       ifid_q, ifid_d;
  if_id_t       hold_q, fetched;
  logic         hold_valid, hold_load, hold_clear;
  logic         hit_taken, accept, is_halt;
  word_t        redir_tgt, pc_inc;

  assign redir_tgt = redirect_pc & ~32'h3;
  assign pc_inc    = pc_q + 32'd4;
  assign hit_taken = ihit && imemREN;
  assign accept    = hit_taken && (state_q == RUN)
                  && !redirect_valid && !flush;
  assign is_halt   = opcode_of(iload) == HALT_OP;
  assign fetched   = '{valid: 1'b1, instr: iload,
                       pc: pc_q, npc: pc_inc};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      redir_q <= '0;
      ifid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if (hit_taken || !imemREN) begin
            pc_d = redir_tgt;
          end else begin
            // keep the miss address stable for the icache
            redir_d = redir_tgt;
            state_d = REDIR_WAIT;
          end
        end else if (accept) begin
          pc_d = pc_inc;
          if (is_halt) state_d = HALTED;
        end
      end
      REDIR_WAIT: begin
        if (redirect_valid) redir_d = redir_tgt;
        if (hit_taken) begin
          pc_d    = redirect_valid ? redir_tgt : redir_q;
          state_d = RUN;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    imemREN = 1'b0;
    halted  = state_q == HALTED;
    if (!RST && state_q != HALTED && !hold_valid) begin
      imemREN = 1'b1;
    end
  end

  always_comb begin
    ifid_d     = ifid_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (flush) begin
      ifid_d.valid = 1'b0;
      hold_clear   = 1'b1;
    end else if (stall) begin
      hold_load = accept;
    end else if (hold_valid) begin
      ifid_d     = hold_q;
      hold_clear = 1'b1;
    end else if (accept) begin
      ifid_d = fetched;
    end else begin
      ifid_d.valid = 1'b0;
    end
  end

  fetch_hold_reg u_hold (
    .clk   (CLK),
    .rst   (RST),
    .load  (hold_load),
    .clear (hold_clear),
    .d     (fetched),
    .valid (hold_valid),
    .q     (hold_q)
  );

  assign imemaddr = pc_q;
  assign if_valid = ifid_q.valid;
  assign if_instr = ifid_q.instr;
  assign if_pc    = ifid_q.pc;
  assign if_npc   = ifid_q.npc;

endmodule
